// File: rtl/img_sram_arbiter_if.sv
// SRAM control type and the requester/SRAM bundle shared by img_sram_arbiter and its users.
// The slave modport is the arbiter's view; the master modport is the requester and SRAM side.
package img_sram_pkg;

  typedef struct packed {
    logic [7:0] din;
    logic [5:0] row;
    logic [5:0] col;
    logic       write_en;
    logic       sense_en;
  } img_sram_ctrl_t;

  // Idle SRAM command: sense amps on, no write, address 0.
  localparam img_sram_ctrl_t SRAM_HOLD = '{din: 8'h00, row: 6'd0, col: 6'd0,
                                           write_en: 1'b0, sense_en: 1'b1};

endpackage

interface img_sram_arbiter_if #(
  parameter int NREQ = 3
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                       req;
  logic [NREQ-1:0]                       lock;
  img_sram_pkg::img_sram_ctrl_t [NREQ-1:0] req_ctrl;
  logic [NREQ-1:0]                       gnt;
  logic [NREQ-1:0]                       rvalid;
  logic [7:0]                            rdata;
  img_sram_pkg::img_sram_ctrl_t          sram_ctrl;
  logic [7:0]                            sram_dout;
  logic [OW-1:0]                         owner;
  logic                                  busy;

  modport slave (
    input  req, lock, req_ctrl, sram_dout,
    output gnt, rvalid, rdata, sram_ctrl, owner, busy
  );

  modport master (
    output req, lock, req_ctrl, sram_dout,
    input  gnt, rvalid, rdata, sram_ctrl, owner, busy
  );

endinterface

// File: rtl/img_sram_arbiter.sv
// Round-robin arbiter sharing one img_sram port between NREQ requesters, with locked bursts bounded
// by MAX_BURST and a registered 1-cycle read-valid. Optional counters under IMG_SRAM_ARB_STATS_EN.
module img_sram_arbiter
  import img_sram_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  img_sram_arbiter_if.slave     bus
`ifdef IMG_SRAM_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [NREQ-1:0][15:0] gnt_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [7:0]      burst_q, burst_d;

  logic            win_found;
  logic [OW-1:0]   win_idx;
  logic            own_req;
  logic            own_lock;
  logic            others_pending;
  logic            burst_hit;
  logic            release_own;
  logic            access;

  function automatic logic [OW-1:0] wrap_idx(input int v);
    return OW'(v % NREQ);
  endfunction

  // First requester at or above the rr pointer, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && bus.req[wrap_idx(int'(ptr_q) + k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(int'(ptr_q) + k);
      end
    end
  end

  assign own_req        = bus.req[owner_q];
  assign own_lock       = bus.lock[owner_q];
  assign others_pending = |(bus.req & ~gnt_q);
  assign burst_hit      = ({1'b0, burst_q} + 9'd1) >= 9'(MAX_BURST);
  assign access         = (state_q == ST_OWNED) && own_req;
  assign release_own    = (state_q == ST_OWNED) &&
                          (!own_req || !own_lock || (burst_hit && others_pending));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      burst_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    rvalid_d = '0;

    if (access && !bus.req_ctrl[owner_q].write_en) begin
      rvalid_d = gnt_q;
    end

    // A releasing owner hands over on the same edge, so no dead cycle between owners.
    if (state_q == ST_IDLE || release_own) begin
      if (win_found) begin
        state_d = ST_OWNED;
        gnt_d   = '0;
        gnt_d[win_idx] = 1'b1;
        owner_d = win_idx;
        ptr_d   = wrap_idx(int'(win_idx) + 1);
        burst_d = '0;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        burst_d = '0;
      end
    end else if (burst_q < 8'(MAX_BURST)) begin
      burst_d = burst_q + 8'd1;
    end
  end

  always_comb begin
    bus.sram_ctrl = SRAM_HOLD;
    if (access) begin
      bus.sram_ctrl = bus.req_ctrl[owner_q];
    end
    bus.gnt    = gnt_q;
    bus.rvalid = rvalid_q;
    bus.rdata  = bus.sram_dout;
    bus.owner  = owner_q;
    bus.busy   = (state_q == ST_OWNED);
  end

`ifdef IMG_SRAM_ARB_STATS_EN
  logic [NREQ-1:0][15:0] gnt_cnt_q, gnt_cnt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      gnt_cnt_q   <= gnt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    gnt_cnt_d   = gnt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      gnt_cnt_d   = '0;
      stall_cnt_d = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_q[i] && bus.req[i] && gnt_cnt_q[i] != 16'hFFFF) begin
          gnt_cnt_d[i] = gnt_cnt_q[i] + 16'd1;
        end
      end
      if (others_pending && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  assign gnt_cnt   = gnt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_img_sram_arbiter.sv
// Directed bench for img_sram_arbiter (NREQ=3, MAX_BURST=4) with a behavioural 64x64 SRAM
// of 1-cycle read latency; counter checks run when IMG_SRAM_ARB_STATS_EN is defined.
module tb_img_sram_arbiter;
  import img_sram_pkg::*;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   wr_cnt = 0;
  int   wr_snap;
  logic [7:0] mem [0:63][0:63];
  logic [2:0] rr_exp [6];
  img_sram_ctrl_t hold_exp;

  img_sram_arbiter_if #(.NREQ(3)) bus();

`ifdef IMG_SRAM_ARB_STATS_EN
  logic            stats_clr;
  logic [2:0][15:0] gnt_cnt;
  logic [15:0]     stall_cnt;
`endif

  img_sram_arbiter #(.NREQ(3), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef IMG_SRAM_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .gnt_cnt   (gnt_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: write on the edge, registered read data on the edge.
  always @(posedge clk) begin
    if (bus.sram_ctrl.write_en) begin
      mem[bus.sram_ctrl.row][bus.sram_ctrl.col] <= bus.sram_ctrl.din;
      wr_cnt <= wr_cnt + 1;
    end else if (bus.sram_ctrl.sense_en) begin
      bus.sram_dout <= mem[bus.sram_ctrl.row][bus.sram_ctrl.col];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic img_sram_ctrl_t mk(input logic [7:0] d, input logic [5:0] r,
                                        input logic [5:0] c, input logic we);
    img_sram_ctrl_t t;
    t.din      = d;
    t.row      = r;
    t.col      = c;
    t.write_en = we;
    t.sense_en = !we;
    return t;
  endfunction

  initial begin
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        mem[r][c] = 8'h00;
    mem[5][7] = 8'hA5;
    hold_exp  = '{din: 8'h00, row: 6'd0, col: 6'd0, write_en: 1'b0, sense_en: 1'b1};
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

    rst = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    bus.req_ctrl[0] = mk(8'h00, 6'd10, 6'd0, 1'b0);
    bus.req_ctrl[1] = mk(8'h00, 6'd11, 6'd0, 1'b0);
    bus.req_ctrl[2] = mk(8'h00, 6'd12, 6'd0, 1'b0);
`ifdef IMG_SRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_gnt",    64'(bus.gnt), 64'h0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
    chk("rst_owner",  64'(bus.owner), 64'h0);
    chk("rst_busy",   64'(bus.busy), 64'h0);
    chk("rst_ctrl",   64'(bus.sram_ctrl), 64'(hold_exp));
    cyc();
    rst = 1'b0;

    // Round robin, single-access grants, back to back
    cyc();
    bus.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("rr_gnt%0d", k), 64'(bus.gnt), 64'(rr_exp[k]));
      if (k > 0) chk($sformatf("rr_rvalid%0d", k), 64'(bus.rvalid), 64'(rr_exp[k-1]));
    end
    cyc();
    bus.req = 3'b000;
    repeat (3) cyc();

    // Reset mid-burst; pointer is 1 here so requester 1 owns the port
    bus.req  = 3'b111;
    bus.lock = 3'b111;
    cyc();
    cyc();
    @(negedge clk);
    chk("pre_rst_gnt",    64'(bus.gnt), 64'b010);
    chk("pre_rst_rvalid", 64'(bus.rvalid), 64'b010);
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt",    64'(bus.gnt), 64'h0);
    chk("mid_rst_rvalid", 64'(bus.rvalid), 64'h0);
    chk("mid_rst_ctrl",   64'(bus.sram_ctrl), 64'(hold_exp));
    chk("mid_rst_busy",   64'(bus.busy), 64'h0);
    cyc();
    rst = 1'b0;
    cyc();
    @(negedge clk);
    chk("post_rst_gnt",   64'(bus.gnt), 64'b001);
    chk("post_rst_owner", 64'(bus.owner), 64'h0);
    cyc();
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    repeat (3) cyc();

    // Burst bound: owner 0 locked, requester 1 waiting
    bus.req  = 3'b001;
    bus.lock = 3'b001;
    cyc();
    bus.req = 3'b011;
    @(negedge clk);
    chk("burst_gnt0", 64'(bus.gnt), 64'b001);
    for (int k = 1; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("burst_gnt%0d", k), 64'(bus.gnt), 64'b001);
    end
    cyc();
    @(negedge clk);
    chk("burst_handover", 64'(bus.gnt), 64'b010);
    chk("burst_owner",    64'(bus.owner), 64'h1);
    cyc();
    bus.req = 3'b001;
    @(negedge clk);
    chk("burst_back_rr", 64'(bus.gnt), 64'b001);
    repeat (6) cyc();
    @(negedge clk);
    chk("burst_alone_keeps", 64'(bus.gnt), 64'b001);
    cyc();
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    repeat (3) cyc();

    // Read by requester 2 from (5,7)
    bus.req_ctrl[2] = mk(8'h00, 6'd5, 6'd7, 1'b0);
    bus.req = 3'b100;
    cyc();
    @(negedge clk);
    chk("rd_gnt",  64'(bus.gnt), 64'b100);
    chk("rd_ctrl", 64'(bus.sram_ctrl), 64'(mk(8'h00, 6'd5, 6'd7, 1'b0)));
    cyc();
    bus.req = 3'b000;
    @(negedge clk);
    chk("rd_rvalid", 64'(bus.rvalid), 64'b100);
    chk("rd_rdata",  64'(bus.rdata), 64'hA5);
    repeat (3) cyc();

    // Locked write then read of (1,1) by requester 0
    bus.req_ctrl[0] = mk(8'h3C, 6'd1, 6'd1, 1'b1);
    bus.req  = 3'b001;
    bus.lock = 3'b001;
    cyc();
    @(negedge clk);
    chk("wr_gnt", 64'(bus.gnt), 64'b001);
    cyc();
    bus.req_ctrl[0] = mk(8'h00, 6'd1, 6'd1, 1'b0);
    @(negedge clk);
    chk("wr_no_rvalid", 64'(bus.rvalid), 64'h0);
    cyc();
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    @(negedge clk);
    chk("wr_rd_rvalid", 64'(bus.rvalid), 64'b001);
    chk("wr_rd_rdata",  64'(bus.rdata), 64'h3C);
    repeat (3) cyc();

    // Requester 1 drops req while granted: no write may reach the SRAM
    bus.req_ctrl[1] = mk(8'h77, 6'd2, 6'd2, 1'b1);
    bus.req  = 3'b010;
    bus.lock = 3'b010;
    cyc();
    bus.req = 3'b000;
    wr_snap = wr_cnt;
    @(negedge clk);
    chk("drop_gnt_held", 64'(bus.gnt), 64'b010);
    chk("drop_ctrl",     64'(bus.sram_ctrl), 64'(hold_exp));
    cyc();
    @(negedge clk);
    chk("drop_gnt_clr", 64'(bus.gnt), 64'h0);
    chk("drop_no_write", 64'(wr_cnt), 64'(wr_snap));
    chk("drop_mem",     64'(mem[2][2]), 64'h00);
    bus.lock = 3'b000;
    repeat (3) cyc();

`ifdef IMG_SRAM_ARB_STATS_EN
    bus.req  = 3'b001;
    bus.lock = 3'b001;
    cyc();
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    bus.req   = 3'b011;
    cyc();
    cyc();
    bus.req = 3'b001;
    cyc();
    bus.req  = 3'b000;
    bus.lock = 3'b000;
    cyc();
    @(negedge clk);
    chk("stats_gnt0",  64'(gnt_cnt[0]), 64'd3);
    chk("stats_gnt1",  64'(gnt_cnt[1]), 64'd0);
    chk("stats_stall", 64'(stall_cnt), 64'd2);
    cyc();
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    @(negedge clk);
    chk("stats_clr_gnt0",  64'(gnt_cnt[0]), 64'd0);
    chk("stats_clr_stall", 64'(stall_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
